river_cross_n: RTL and testbench

- Parametrised N-item river-crossing puzzle engine, successor to the fixed 3-item wolf/sheep/cabbage model.
- Items, boat capacity and the conflict relation are parameters; move-limit and safety checks run in RTL.
- Rule enforcement is in RTL, not in restrict constraints. Each proposed move is checked, then accepted or rejected with an error code.
- Sits under the formal/simulation harness; the cover target is solved.

---
 rtl/river_pkg.sv | 28 ++
 rtl/river_safe_chk.sv | 22 ++
 rtl/river_cross_n.sv | 166 ++++++++++++++++
 tb/tb_river_cross_n.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
// Shared types for the N-item river-crossing engine: response codes, FSM
// states and a popcount helper.
package river_pkg;

   typedef enum logic [2:0] {
      OK         = 3'd0,
      OVER_CAP   = 3'd1,
      WRONG_SIDE = 3'd2,
      UNSAFE     = 3'd3,
      EMPTY      = 3'd6
   } err_t;

   typedef enum logic [1:0] {
      PLAY,
      SOLVED,
      FAILED
   } fsm_t;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/river_safe_chk.sv
// Flags a bank whose item mask holds any pair marked as conflicting in the
// flat N_ITEMS x N_ITEMS CONFLICT matrix (bit i*N_ITEMS+j: item i harms j).
module river_safe_chk
   import river_pkg::*;
#(
   parameter int unsigned                  N_ITEMS  = 3,
   parameter logic [N_ITEMS*N_ITEMS-1:0]   CONFLICT = 9'h0AA
) (
   input  logic [N_ITEMS-1:0] bank,
   output logic               unsafe
);

   always_comb begin
      unsafe = 1'b0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         for (int unsigned j = 0; j < N_ITEMS; j++) begin
            if (i != j && CONFLICT[i*N_ITEMS+j] && bank[i] && bank[j]) unsafe = 1'b1;
         end
      end
   end

endmodule

// File: rtl/river_cross_n.sv
// Parametrised river-crossing engine: checks each proposed move, answers one
// cycle later with an error code. Optional undo history under RIVER_UNDO_EN.
module river_cross_n
   import river_pkg::*;
#(
   parameter int unsigned                  N_ITEMS    = 3,
   parameter int unsigned                  BOAT_CAP   = 1,
   parameter logic [N_ITEMS*N_ITEMS-1:0]   CONFLICT   = 9'h0AA,
   parameter int unsigned                  MOVE_LIMIT = 15,
   parameter int unsigned                  CNT_W      = 4,
   parameter int unsigned                  HIST_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               move_valid,
   input  logic [N_ITEMS-1:0] move_sel,
   output logic               move_ready,
   input  logic               restart,
`ifdef RIVER_UNDO_EN
   input  logic               undo_valid,
`endif
   output logic               resp_valid,
   output logic [2:0]         resp_err,
   output logic [N_ITEMS:0]   state,
   output logic [CNT_W-1:0]   move_cnt,
   output logic               solved,
   output logic               failed
);

   // A misconfigured instance never accepts a move.
   localparam bit CFG_OK = (MOVE_LIMIT >= 1) && (MOVE_LIMIT <= (1 << CNT_W) - 1)
                           && (HIST_DEPTH >= 2);

   fsm_t               fsm;
   err_t               chk_err;
   logic               farmer;
   logic [N_ITEMS-1:0] items;
   logic [N_ITEMS-1:0] new_items;
   logic [N_ITEMS-1:0] dep_bank;
   logic [N_ITEMS-1:0] wrong_mask;
   logic [N_ITEMS:0]   next_state;
   logic [CNT_W-1:0]   next_cnt;
   logic               unsafe;
   logic               take;

   assign farmer = state[N_ITEMS];
   assign items  = state[N_ITEMS-1:0];

   // Departure bank is judged on the post-move position of the items.
   always_comb begin
      new_items  = items ^ move_sel;
      dep_bank   = farmer ? new_items : ~new_items;
      wrong_mask = move_sel & (farmer ? ~items : items);
      next_state = {~farmer, new_items};
      next_cnt   = move_cnt + CNT_W'(1);
      if (popcount(32'(move_sel)) > BOAT_CAP) chk_err = OVER_CAP;
      else if (|wrong_mask)                   chk_err = WRONG_SIDE;
      else if (unsafe)                        chk_err = UNSAFE;
      else                                    chk_err = OK;
   end

   river_safe_chk #(
      .N_ITEMS  (N_ITEMS),
      .CONFLICT (CONFLICT)
   ) u_safe (
      .bank   (dep_bank),
      .unsafe (unsafe)
   );

`ifdef RIVER_UNDO_EN
   assign move_ready = CFG_OK && (fsm == PLAY) && !undo_valid;
`else
   assign move_ready = CFG_OK && (fsm == PLAY);
`endif

   assign take = move_valid && move_ready;

`ifdef RIVER_UNDO_EN
   localparam int unsigned HW  = $clog2(HIST_DEPTH);
   localparam int unsigned HCW = $clog2(HIST_DEPTH + 1);

   logic [N_ITEMS:0] hist [HIST_DEPTH];
   logic [HW-1:0]    hist_top;
   logic [HW-1:0]    top_inc;
   logic [HW-1:0]    top_dec;
   logic [HCW-1:0]   hist_cnt;
   logic             push;

   // Circular LIFO: a push onto a full history overwrites the oldest entry.
   always_comb begin
      top_inc = (hist_top == HW'(HIST_DEPTH - 1)) ? '0 : hist_top + HW'(1);
      top_dec = (hist_top == '0) ? HW'(HIST_DEPTH - 1) : hist_top - HW'(1);
      push    = take && !restart && (chk_err == OK);
   end

   always_ff @(posedge clk) begin
      if (push) hist[hist_top] <= state;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm        <= PLAY;
         state      <= '0;
         move_cnt   <= '0;
         resp_valid <= 1'b0;
         resp_err   <= '0;
         solved     <= 1'b0;
         failed     <= 1'b0;
`ifdef RIVER_UNDO_EN
         hist_top   <= '0;
         hist_cnt   <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         if (restart) begin
            fsm      <= PLAY;
            state    <= '0;
            move_cnt <= '0;
            solved   <= 1'b0;
            failed   <= 1'b0;
`ifdef RIVER_UNDO_EN
            hist_top <= '0;
            hist_cnt <= '0;
`endif
         end
`ifdef RIVER_UNDO_EN
         else if (undo_valid) begin
            resp_valid <= 1'b1;
            if (hist_cnt == '0) begin
               resp_err <= EMPTY;
            end else begin
               resp_err <= OK;
               state    <= hist[top_dec];
               move_cnt <= move_cnt - CNT_W'(1);
               hist_top <= top_dec;
               hist_cnt <= hist_cnt - HCW'(1);
               fsm      <= PLAY;
               solved   <= 1'b0;
               failed   <= 1'b0;
            end
         end
`endif
         else if (take) begin
            resp_valid <= 1'b1;
            resp_err   <= chk_err;
            if (chk_err == OK) begin
               state    <= next_state;
               move_cnt <= next_cnt;
`ifdef RIVER_UNDO_EN
               hist_top <= top_inc;
               if (hist_cnt != HCW'(HIST_DEPTH)) hist_cnt <= hist_cnt + HCW'(1);
`endif
               if (&next_state) begin
                  fsm    <= SOLVED;
                  solved <= 1'b1;
               end else if (next_cnt == CNT_W'(MOVE_LIMIT)) begin
                  fsm    <= FAILED;
                  failed <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_river_cross_n.sv
// Bench for river_cross_n: directed puzzle scenarios plus random moves checked
// against a bank-by-bank model of the wolf/sheep/cabbage rules.
module tb_river_cross_n;

   localparam int unsigned N     = 3;
   localparam int unsigned LIMIT = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         move_valid;
   logic [N-1:0] move_sel;
   logic         move_ready;
   logic         restart;
   logic         resp_valid;
   logic [2:0]   resp_err;
   logic [N:0]   state;
   logic [3:0]   move_cnt;
   logic         solved;
   logic         failed;
`ifdef RIVER_UNDO_EN
   logic         undo_valid;
`endif

   int n_vec = 0;
   int n_bad = 0;

   // Model: side of farmer and each item (0 near, 1 far), count, game mode.
   int m_farmer;
   int m_bank[N];
   int m_cnt;
   int m_mode;   // 0 playing, 1 solved, 2 failed

   always #5 clk = ~clk;

   river_cross_n #(
      .N_ITEMS    (3),
      .BOAT_CAP   (1),
      .CONFLICT   (9'h0AA),
      .MOVE_LIMIT (15),
      .CNT_W      (4),
      .HIST_DEPTH (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .move_valid (move_valid),
      .move_sel   (move_sel),
      .move_ready (move_ready),
      .restart    (restart),
`ifdef RIVER_UNDO_EN
      .undo_valid (undo_valid),
`endif
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .state      (state),
      .move_cnt   (move_cnt),
      .solved     (solved),
      .failed     (failed)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Item 2 = wolf, 1 = sheep, 0 = cabbage.
   function automatic bit harms(int a, int b);
      return (a == 2 && b == 1) || (a == 1 && b == 2) ||
             (a == 1 && b == 0) || (a == 0 && b == 1);
   endfunction

   function automatic void model_reset();
      m_farmer = 0;
      foreach (m_bank[i]) m_bank[i] = 0;
      m_cnt  = 0;
      m_mode = 0;
   endfunction

   function automatic logic [N:0] m_state();
      logic [N:0] s;
      for (int i = 0; i < N; i++) s[i] = (m_bank[i] != 0);
      s[N] = (m_farmer != 0);
      return s;
   endfunction

   function automatic int model_err(logic [N-1:0] sel);
      int carried;
      int post[N];
      carried = 0;
      for (int i = 0; i < N; i++) if (sel[i]) carried++;
      if (carried > 1) return 1;
      for (int i = 0; i < N; i++) if (sel[i] && m_bank[i] != m_farmer) return 2;
      for (int i = 0; i < N; i++) post[i] = sel[i] ? 1 - m_bank[i] : m_bank[i];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (i != j && post[i] == m_farmer && post[j] == m_farmer && harms(i, j)) return 3;
      return 0;
   endfunction

   function automatic void model_apply(logic [N-1:0] sel);
      bool_all: begin
         int all_far;
         m_farmer = 1 - m_farmer;
         for (int i = 0; i < N; i++) if (sel[i]) m_bank[i] = 1 - m_bank[i];
         m_cnt++;
         all_far = m_farmer;
         for (int i = 0; i < N; i++) if (m_bank[i] == 0) all_far = 0;
         if (all_far != 0) m_mode = 1;
         else if (m_cnt == LIMIT) m_mode = 2;
      end
   endfunction

   task automatic check_state();
      chk("state",    32'(state),    32'(m_state()));
      chk("move_cnt", 32'(move_cnt), m_cnt);
      chk("solved",   32'(solved),   32'(m_mode == 1));
      chk("failed",   32'(failed),   32'(m_mode == 2));
   endtask

   task automatic apply(input logic [N-1:0] sel, input bit rs);
      bit rdy;
      int e;
      @(negedge clk);
      chk("move_ready", 32'(move_ready), 32'(m_mode == 0));
      rdy        = (m_mode == 0);
      move_valid = 1'b1;
      move_sel   = sel;
      restart    = rs;
      @(posedge clk);
      #1;
      move_valid = 1'b0;
      restart    = 1'b0;
      if (rs) begin
         model_reset();
         chk("resp_valid_restart", 32'(resp_valid), 0);
      end else if (rdy) begin
         e = model_err(sel);
         chk("resp_valid", 32'(resp_valid), 1);
         chk("resp_err",   32'(resp_err),   e);
         if (e == 0) model_apply(sel);
      end else begin
         chk("resp_valid_ignored", 32'(resp_valid), 0);
      end
      check_state();
   endtask

   task automatic idle_chk();
      @(posedge clk);
      #1;
      chk("resp_valid_idle", 32'(resp_valid), 0);
   endtask

`ifdef RIVER_UNDO_EN
   task automatic undo(input logic [2:0] exp_err, input logic [N:0] exp_state, input int exp_cnt);
      @(negedge clk);
      undo_valid = 1'b1;
      move_valid = 1'b1;
      move_sel   = 3'b010;
      #1;
      chk("undo_ready", 32'(move_ready), 0);
      @(posedge clk);
      #1;
      undo_valid = 1'b0;
      move_valid = 1'b0;
      chk("undo_rv",    32'(resp_valid), 1);
      chk("undo_err",   32'(resp_err),   32'(exp_err));
      chk("undo_state", 32'(state),      32'(exp_state));
      chk("undo_cnt",   32'(move_cnt),   exp_cnt);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] classic[7];
      logic [N-1:0] sel;
      bit           rs;

      classic = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
      rst        = 1'b1;
      move_valid = 1'b0;
      move_sel   = '0;
      restart    = 1'b0;
`ifdef RIVER_UNDO_EN
      undo_valid = 1'b0;
`endif
      model_reset();

      #12;
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_err",   32'(resp_err),   0);
      check_state();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_move_ready", 32'(move_ready), 1);

      // Classic seven-move solution.
      foreach (classic[k]) begin
         apply(classic[k], 1'b0);
         chk("classic_err", 32'(resp_err), 0);
      end
      chk("classic_state",  32'(state),    32'h0F);
      chk("classic_solved", 32'(solved),   1);
      chk("classic_cnt",    32'(move_cnt), 7);
      idle_chk();
      apply(3'b010, 1'b0);
      chk("solved_ready", 32'(move_ready), 0);

      // Rejection codes.
      apply(3'b000, 1'b1);
      apply(3'b100, 1'b0);
      chk("wolf_unsafe", 32'(resp_err), 3);
      chk("wolf_state",  32'(state),    0);
      apply(3'b011, 1'b0);
      chk("two_over_cap", 32'(resp_err), 1);
      apply(3'b010, 1'b0);
      chk("first_state", 32'(state), 32'h0A);
      apply(3'b001, 1'b0);
      chk("wrong_side", 32'(resp_err), 2);

      // Exhaust the move limit by ferrying the sheep back and forth.
      apply(3'b000, 1'b1);
      for (int k = 0; k < int'(LIMIT); k++) apply(3'b010, 1'b0);
      chk("limit_failed", 32'(failed),     1);
      chk("limit_ready",  32'(move_ready), 0);
      apply(3'b010, 1'b0);
      apply(3'b010, 1'b1);
      chk("restart_state", 32'(state),      0);
      chk("restart_cnt",   32'(move_cnt),   0);
      chk("restart_ready", 32'(move_ready), 1);

      // Random moves, occasional restart (sometimes colliding with a move).
      for (int k = 0; k < 400; k++) begin
         sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) sel = 3'(1 << $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) sel = 3'b000;
         rs = ($urandom_range(0, 39) == 0) || (m_mode != 0 && $urandom_range(0, 2) == 0);
         apply(sel, rs);
         if ($urandom_range(0, 7) == 0) idle_chk();
      end

      // Asynchronous reset while a response is pending.
      apply(3'b000, 1'b1);
      apply(3'b010, 1'b0);
      @(negedge clk);
      move_valid = 1'b1;
      move_sel   = 3'b000;
      @(posedge clk);
      #2;
      rst        = 1'b1;
      move_valid = 1'b0;
      #1;
      chk("arst_resp_valid", 32'(resp_valid), 0);
      chk("arst_resp_err",   32'(resp_err),   0);
      model_reset();
      check_state();
      @(negedge clk);
      rst = 1'b0;
      idle_chk();

`ifdef RIVER_UNDO_EN
      apply(3'b010, 1'b0);
      apply(3'b000, 1'b0);
      undo(3'd0, 4'b1010, 1);
      undo(3'd0, 4'b0000, 0);
      undo(3'd6, 4'b0000, 0);
      model_reset();
      apply(3'b010, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
